// File: rtl/cursor_pkg.sv
// rtl/cursor_pkg.sv - shared types and helpers for the cursor controller
package cursor_pkg;

  // Default geometry and timing for a 50 MHz board clock.
  localparam int NUM_COLS_DEFAULT        = 6;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int BLINK_CYCLES_DEFAULT    = 12500000;

  // Column index as seen by the display driver; eight columns at most.
  typedef logic [2:0] col_t;

  // Per-button debouncer state.
  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    CHK_PRESS = 2'd1,
    PRESSED   = 2'd2,
    CHK_REL   = 2'd3
  } deb_state_t;

  // Row encodings understood by the display driver.
  localparam logic ROW_DOWN = 1'b0;
  localparam logic ROW_UP   = 1'b1;

  // Step one column right, wrapping from the last column back to 0.
  function automatic col_t col_step_right(input col_t col, input int num_cols);
    col_t last;
    last = col_t'(num_cols - 1);
    return (col == last) ? col_t'(0) : col + col_t'(1);
  endfunction

  // Step one column left, wrapping from column 0 to the last column.
  function automatic col_t col_step_left(input col_t col, input int num_cols);
    col_t last;
    last = col_t'(num_cols - 1);
    return (col == col_t'(0)) ? last : col - col_t'(1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus debounce FSM, one pulse per press
module btn_debounce
  import cursor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic press_pulse_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync_1;
  logic             r_sync_2;
  deb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;

  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_settled;
  logic             w_level_n;

  // The counter is judged on its incremented value so the level is
  // accepted on exactly the DEBOUNCE_CYCLES-th stable cycle after sync.
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_settled = (w_cnt_inc >= CNT_LAST);
  assign w_level_n = r_sync_2;

  // Bring the asynchronous key into the clock domain; idle level is released (1).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync_1 <= 1'b1;
      r_sync_2 <= 1'b1;
    end else begin
      r_sync_1 <= btn_n_i;
      r_sync_2 <= r_sync_1;
    end
  end

  // Debounce FSM: a press pulse only after a full stable press window, none on release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        RELEASED: begin
          if (!w_level_n) begin
            r_state <= CHK_PRESS;
            r_cnt   <= '0;
          end
        end
        CHK_PRESS: begin
          if (w_level_n) begin
            r_state <= RELEASED;
          end else if (w_settled) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
            r_pulse <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        PRESSED: begin
          if (w_level_n) begin
            r_state <= CHK_REL;
            r_cnt   <= '0;
          end
        end
        CHK_REL: begin
          if (!w_level_n) begin
            r_state <= PRESSED;
          end else if (w_settled) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= RELEASED;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign press_pulse_o = r_pulse;

endmodule

// File: rtl/cursor_ctrl.sv
// rtl/cursor_ctrl.sv - debounced push-buttons to cursor column/row with blink enable
module cursor_ctrl
  import cursor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int BLINK_CYCLES    = BLINK_CYCLES_DEFAULT,
  parameter int NUM_COLS        = NUM_COLS_DEFAULT   // valid range 2..8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_left_n_i,
  input  logic       btn_right_n_i,
  input  logic       btn_row_n_i,
  output logic [2:0] col_o,
  output logic       row_o,
  output logic       move_o,
  output logic       blink_o
);

  localparam int BLK_W = $clog2(BLINK_CYCLES + 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);

  logic w_left;
  logic w_right;
  logic w_row;

  col_t w_col_next;
  logic w_row_next;
  logic w_changed;

  col_t             r_col;
  logic             r_row;
  logic             r_move;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .btn_n_i       (btn_left_n_i),
    .press_pulse_o (w_left)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .btn_n_i       (btn_right_n_i),
    .press_pulse_o (w_right)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_row (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .btn_n_i       (btn_row_n_i),
    .press_pulse_o (w_row)
  );

  // Next position: opposing left/right presses cancel; the row toggle is independent.
  always_comb begin
    w_col_next = r_col;
    if (w_right && !w_left) begin
      w_col_next = col_step_right(r_col, NUM_COLS);
    end else if (w_left && !w_right) begin
      w_col_next = col_step_left(r_col, NUM_COLS);
    end
    w_row_next = r_row ^ w_row;
    w_changed  = (w_col_next != r_col) || (w_row_next != r_row);
  end

  // Register position; move pulse accompanies the first cycle of a new position.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_col  <= col_t'(0);
      r_row  <= ROW_DOWN;
      r_move <= 1'b0;
    end else begin
      r_col  <= w_col_next;
      r_row  <= w_row_next;
      r_move <= w_changed;
    end
  end

  // Blink half-period timer; a move restarts it with the cursor visible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (w_changed) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (r_blink_cnt == BLK_LAST) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLK_W'(1);
    end
  end

  assign col_o   = r_col;
  assign row_o   = r_row;
  assign move_o  = r_move;
  assign blink_o = r_blink;

endmodule
